// File: rtl/bp_update_sched.sv
// bp_update_sched: two-port round-robin scheduler applying resolved branch outcomes to a 1-bit predictor table.
// Optional BP_UPDATE_SCHED_STATS_EN adds a saturating 8-bit mispredict counter (tied to 0 otherwise).
`default_nettype none

module bp_update_sched #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [IDX_W-1:0] req0_index,
  input  logic             req0_taken,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IDX_W-1:0] req1_index,
  input  logic             req1_taken,
  output logic             req1_ready,
  input  logic [IDX_W-1:0] pred_index,
  output logic             pred_taken,
  output logic             upd_done,
  output logic             upd_mispredict,
  output logic [7:0]       mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state;
  logic [DEPTH-1:0] pht;
  logic             prio;       // 0: port 0 holds priority, 1: port 1
  logic [IDX_W-1:0] cap_index;
  logic             cap_taken;

  logic grant0;
  logic grant1;
  logic mismatch;

  // A lone requester wins regardless of priority; contention resolved by prio.
  assign grant0   = req0_valid && (!req1_valid || !prio);
  assign grant1   = req1_valid && (!req0_valid ||  prio);
  assign mismatch = pht[cap_index] != cap_taken;

  // rst gates the handshake and completion so an in-flight update vanishes without a trace.
  assign req0_ready     = !rst && (state == IDLE) && grant0;
  assign req1_ready     = !rst && (state == IDLE) && grant1;
  assign upd_done       = !rst && (((state == CHECK) && !mismatch) || (state == WRITE));
  assign upd_mispredict = !rst && (state == WRITE);
  assign pred_taken     = pht[pred_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pht       <= '1;
      prio      <= 1'b0;
      cap_index <= '0;
      cap_taken <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            cap_index <= req0_index;
            cap_taken <= req0_taken;
            prio      <= 1'b1;
            state     <= CHECK;
          end else if (grant1) begin
            cap_index <= req1_index;
            cap_taken <= req1_taken;
            prio      <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          state <= mismatch ? WRITE : IDLE;
        end
        WRITE: begin
          pht[cap_index] <= ~pht[cap_index];
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_UPDATE_SCHED_STATS_EN
  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if ((state == WRITE) && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign mispredict_count = count_q;
`else
  assign mispredict_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: doc/bp_update_sched.md
BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 Parameter IDX_W, default 3, predictor table index width; table depth SHALL be 2**IDX_W entries.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a resolved branch outcome to apply.
REQ-005 req0_index  input  IDX_W  table entry for requester 0.
REQ-006 req0_taken  input  1  resolved direction for requester 0 (1 = taken).
REQ-007 req0_ready  output  1  requester 0 accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_index, req1_taken, req1_ready  same directions, widths and meanings as REQ-004..REQ-007, for requester 1.
REQ-009 pred_index  input  IDX_W  lookup index.
REQ-010 pred_taken  output  1  combinational read of table entry pred_index.
REQ-011 upd_done  output  1  one-cycle pulse when an accepted request finishes.
REQ-012 upd_mispredict  output  1  valid with upd_done; 1 when the outcome differed from the stored bit.
REQ-013 mispredict_count  output  8  saturating count of mispredicted updates.

Function
REQ-014 Table SHALL be 2**IDX_W one-bit entries; an entry is flipped only when the resolved outcome differs from it.
REQ-015 FSM states SHALL be IDLE, CHECK, WRITE.
REQ-016 IDLE: arbitration; at most one reqN_ready high; reqN_ready SHALL be 0 in CHECK and WRITE.
REQ-017 Arbitration SHALL be round-robin: with both valid, the port holding priority wins; with one valid, that port wins regardless of priority.
REQ-018 After a handshake on port p, priority SHALL pass to the other port; priority SHALL be unchanged in cycles with no handshake.
REQ-019 Handshake (valid && ready) SHALL capture index and taken into internal registers; IDLE -> CHECK.
REQ-020 CHECK: mismatch = table[captured index] != captured taken; mismatch -> WRITE; else assert upd_done=1, upd_mispredict=0, -> IDLE.
REQ-021 WRITE: table[captured index] inverted at the end of the cycle; upd_done=1, upd_mispredict=1; -> IDLE.
REQ-022 Latency: hit completes 1 cycle after accept, mispredict 2 cycles; next accept no earlier than the cycle after upd_done.
REQ-023 pred_taken SHALL reflect the old value through the WRITE cycle and the new value from the following cycle; no forwarding.
REQ-024 Both ports requesting the same index SHALL be serialized; the second update SHALL compare against the post-flip value.
REQ-025 Inputs of a non-granted port are ignored; the requester holds valid/index/taken until its ready.
REQ-026 mispredict_count SHALL increment by 1 in each WRITE cycle and hold at 255.

Reset
REQ-027 rst SHALL force: state IDLE, all table entries 1 (predict taken), priority to port 0, mispredict_count 0, upd_done 0, upd_mispredict 0, captured registers 0.
REQ-028 rst asserted in CHECK or WRITE SHALL discard the in-flight update (no table write, no upd_done); rst overrides all other activity that cycle.
REQ-029 req0_ready and req1_ready SHALL be 0 while rst is high.

Configuration
REQ-030 Macro BP_UPDATE_SCHED_STATS_EN: defined -> mispredict_count behaves per REQ-026; undefined -> no counter register, mispredict_count tied to 0; all other behaviour identical.

Verification
REQ-031 Reset then pred_index=0..7 -> pred_taken=1 for every index; mispredict_count=0.
REQ-032 req0 valid, index 2, taken 0 -> ready cycle N, WRITE N+2 with upd_done=upd_mispredict=1, pred_taken(2)=0 from N+3, count=1.
REQ-033 req1 valid, index 5, taken 1 after reset -> upd_done at N+1, upd_mispredict=0, table unchanged, count=0.
REQ-034 Both valid every cycle, distinct indices -> grants alternate 0,1,0,1; never both ready; no request lost.
REQ-035 Both valid, index 3, taken 0, from reset -> port 0 flips entry 3 to 0 (mispredict); port 1 then hits (upd_mispredict=0); final entry 3 = 0.
REQ-036 rst pulsed in WRITE of a mispredict -> entry unchanged (1), no upd_done, FSM IDLE next cycle; with STATS_EN, 300 mispredicts -> count=255.
